ps2_keyboard_rx: RTL and testbench

// - PS/2 keyboard receiver and scan-code decoder; produces the ps2_byte/ps2_state pair that
//   the keyboard control logic turns into left/right/down/play/restart key presses.
// - Samples the raw PS/2 clock/data lines, deframes 11-bit device-to-host frames, decodes
//   set-2 make/break codes to ASCII, and holds ps2_state high while the mapped key is held.

---
 rtl/ps2_keyboard_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module  : ps2_keyboard_rx
// Brief   : PS/2 keyboard receiver. Synchronizes and de-glitches the raw
//           PS/2 lines, deframes 11-bit device-to-host frames, and decodes
//           set-2 make/break codes into an ASCII key plus a held flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int c_FW = $clog2(FILTER_LEN) + 1;
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_FW-1:0] c_FILT_LAST = c_FW'(FILTER_LEN - 1);
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] c_CODE_EXT = 8'hE0;
  localparam logic [7:0] c_CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_filt_clk;
  logic [c_FW-1:0] r_filt_cnt;
  logic            w_strobe;

  state_t          r_state, w_state_n;
  logic [2:0]      r_bitcnt, w_bitcnt_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            r_par_ok, w_par_ok_n;
  logic [c_TW-1:0] r_tmo, w_tmo_n;
  logic            w_good, w_err;

  logic            r_ext, r_brk;
  logic            w_mapped;
  logic [7:0]      w_ascii;

  // Two-flop synchronizers on both raw lines, preset to the idle-high level.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN differing samples in a row.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == c_FILT_LAST) begin
      r_filt_clk <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // Sample strobe: the cycle in which the filtered clock is about to fall.
  assign w_strobe = r_filt_clk && !r_clk_s2 && (r_filt_cnt == c_FILT_LAST);

  // Frame FSM state and datapath registers.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par_ok <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_par_ok <= w_par_ok_n;
      r_tmo    <= w_tmo_n;
    end
  end

  // Frame FSM next-state: deframing, parity/stop checking and inactivity timeout.
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_par_ok_n = r_par_ok;
    w_tmo_n    = '0;
    w_good     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          if (!r_dat_s2) begin
            w_state_n  = S_DATA;
            w_bitcnt_n = '0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_strobe) begin
          w_shift_n  = {r_dat_s2, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_n = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_strobe) begin
          w_par_ok_n = (^r_shift) ^ r_dat_s2;
          w_state_n  = S_STOP;
        end
      end
      default: begin
        if (w_strobe) begin
          if (r_dat_s2 && r_par_ok) w_good = 1'b1;
          else                      w_err  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
    endcase
    // Inactivity timeout applies to every in-frame state.
    if (r_state != S_IDLE && !w_strobe) begin
      if (r_tmo == c_TMO_LAST) begin
        w_state_n = S_IDLE;
        w_err     = 1'b1;
      end else begin
        w_tmo_n = r_tmo + 1'b1;
      end
    end
  end

  // Registered frame results.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= w_good;
      frame_err  <= w_err;
      if (w_good) scan_code <= r_shift;
    end
  end

  // Set-2 scan code to ASCII lookup for the supported keys.
  always_comb begin
    w_mapped = 1'b1;
    w_ascii  = 8'h00;
    case (scan_code)
      8'h1C: w_ascii = 8'h41;  8'h32: w_ascii = 8'h42;  8'h21: w_ascii = 8'h43;
      8'h23: w_ascii = 8'h44;  8'h24: w_ascii = 8'h45;  8'h2B: w_ascii = 8'h46;
      8'h34: w_ascii = 8'h47;  8'h33: w_ascii = 8'h48;  8'h43: w_ascii = 8'h49;
      8'h3B: w_ascii = 8'h4A;  8'h42: w_ascii = 8'h4B;  8'h4B: w_ascii = 8'h4C;
      8'h3A: w_ascii = 8'h4D;  8'h31: w_ascii = 8'h4E;  8'h44: w_ascii = 8'h4F;
      8'h4D: w_ascii = 8'h50;  8'h15: w_ascii = 8'h51;  8'h2D: w_ascii = 8'h52;
      8'h1B: w_ascii = 8'h53;  8'h2C: w_ascii = 8'h54;  8'h3C: w_ascii = 8'h55;
      8'h2A: w_ascii = 8'h56;  8'h1D: w_ascii = 8'h57;  8'h22: w_ascii = 8'h58;
      8'h35: w_ascii = 8'h59;  8'h1A: w_ascii = 8'h5A;
      8'h45: w_ascii = 8'h30;  8'h16: w_ascii = 8'h31;  8'h1E: w_ascii = 8'h32;
      8'h26: w_ascii = 8'h33;  8'h25: w_ascii = 8'h34;  8'h2E: w_ascii = 8'h35;
      8'h36: w_ascii = 8'h36;  8'h3D: w_ascii = 8'h37;  8'h3E: w_ascii = 8'h38;
      8'h46: w_ascii = 8'h39;
      8'h29: w_ascii = 8'h20;  8'h5A: w_ascii = 8'h0D;
      default: w_mapped = 1'b0;
    endcase
  end

  // Make/break decoder; prefix flags live for exactly one following code.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      ps2_byte  <= '0;
      ps2_state <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == c_CODE_EXT) begin
        r_ext <= 1'b1;
      end else if (scan_code == c_CODE_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_ext && w_mapped) begin
          if (!r_brk) begin
            ps2_byte  <= w_ascii;
            ps2_state <= 1'b1;
          end else if (w_ascii == ps2_byte) begin
            ps2_state <= 1'b0;
          end
        end
      end
    end else if (frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
// ============================================================================
// Module  : tb_ps2_keyboard_rx
// Brief   : Self-checking bench for ps2_keyboard_rx: directed key scenarios
//           followed by random scan-code streams against a key-table model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_keyboard_rx;

  localparam int HALF = 30;     // PS/2 clock half period in system cycles
  localparam int TMO  = 1000;   // shortened timeout for simulation

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] ps2_byte, scan_code;
  logic       ps2_state, scan_valid, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;

  // Reference model state
  logic [7:0] ascii_of [logic [7:0]];
  logic [7:0] key_list [$];
  bit         m_ext, m_brk, m_state;
  logic [7:0] m_byte;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_50M    (clk),
    .RST        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_byte   (ps2_byte),
    .ps2_state  (ps2_state),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #10 clk = ~clk;

  // Count result pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (scan_valid) sv_cnt++;
      if (frame_err)  fe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic build_map();
    logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    for (int i = 0; i < 26; i++) ascii_of[letters[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) ascii_of[digits[i]]  = 8'h30 + 8'(i);
    ascii_of[8'h29] = 8'h20;
    ascii_of[8'h5A] = 8'h0D;
    foreach (ascii_of[k]) key_list.push_back(k);
  endtask

  // Keyboard behaviour as the key table describes it.
  task automatic model_code(input logic [7:0] code, input bit good);
    if (!good) begin
      m_ext = 0; m_brk = 0;
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (!m_ext && ascii_of.exists(code)) begin
        if (!m_brk) begin
          m_byte  = ascii_of[code];
          m_state = 1;
        end else if (ascii_of[code] == m_byte) begin
          m_state = 0;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Drive nbits of a frame onto the lines; optionally a 4-cycle clock glitch after bit 3.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
      if (glitch && i == 3) begin
        cyc(HALF / 2);
        ps2_clk = 1'b0;
        cyc(4);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                       input bit glitch, input string tag);
    int  sv0, fe0;
    bit  good;
    logic par;
    sv0  = sv_cnt;
    fe0  = fe_cnt;
    par  = ~(^code) ^ bad_par;
    good = !bad_par && !bad_stop;
    drive_bits({~bad_stop, par, code, 1'b0}, 11, glitch);
    cyc(HALF);
    ps2_data = 1'b1;
    cyc(20);
    model_code(code, good);
    check({tag, ".valid"}, sv_cnt - sv0, good ? 1 : 0);
    check({tag, ".err"},   fe_cnt - fe0, good ? 0 : 1);
    if (good) check({tag, ".code"}, scan_code, code);
    check({tag, ".byte"},  ps2_byte, m_byte);
    check({tag, ".state"}, ps2_state, m_state);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv0, fe0;
    logic [7:0] code;
    build_map();
    m_ext = 0; m_brk = 0; m_state = 0; m_byte = 8'h00;

    cyc(5);
    #1;
    check("rst.byte", ps2_byte, 0);
    check("rst.state", ps2_state, 0);
    check("rst.code", scan_code, 0);
    check("rst.pulses", {30'd0, scan_valid, frame_err}, 0);
    @(posedge clk);
    rst = 1'b0;
    cyc(20);

    // Directed key scenarios
    frame(8'h1C, 0, 0, 0, "make_A");
    check("A.ascii", ps2_byte, 8'h41);
    frame(8'hF0, 0, 0, 0, "brk_pfx");
    frame(8'h1C, 0, 0, 0, "brk_A");
    frame(8'h23, 0, 0, 0, "make_D");
    frame(8'h1C, 0, 0, 0, "make_A2");
    frame(8'hF0, 0, 0, 0, "brk_pfx2");
    frame(8'h23, 0, 0, 0, "brk_D");
    frame(8'hF0, 0, 0, 0, "brk_pfx3");
    frame(8'h1C, 0, 0, 0, "brk_A2");
    frame(8'hE0, 0, 0, 0, "ext_pfx");
    frame(8'h6B, 0, 0, 0, "ext_left");
    frame(8'h1B, 0, 0, 0, "make_S");
    frame(8'h4D, 1, 0, 0, "bad_par");
    frame(8'h4D, 0, 1, 0, "bad_stop");

    // Timeout after 5 data bits
    sv0 = sv_cnt; fe0 = fe_cnt;
    drive_bits({1'b1, 1'b1, 8'h55, 1'b0}, 6, 0);
    ps2_data = 1'b1;
    cyc(TMO + 100);
    model_code(8'h00, 0);
    check("tmo.err", fe_cnt - fe0, 1);
    check("tmo.valid", sv_cnt - sv0, 0);
    check("tmo.byte", ps2_byte, m_byte);
    frame(8'h2D, 0, 0, 0, "make_R");
    check("R.ascii", ps2_byte, 8'h52);

    // Clock glitches: idle and mid-frame
    fe0 = fe_cnt;
    ps2_clk = 1'b0; cyc(4); ps2_clk = 1'b1;
    cyc(40);
    check("glitch_idle.err", fe_cnt - fe0, 0);
    frame(8'h32, 0, 0, 1, "glitch_frame");

    // Random code stream
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      code = key_list[$urandom_range(0, key_list.size() - 1)];
      else if (r < 65) code = 8'hF0;
      else if (r < 72) code = 8'hE0;
      else if (r < 85) code = m_state ? 8'hF0 : 8'h29;
      else             code = 8'($urandom_range(0, 255));
      if (code == 8'hF0 && m_brk) code = key_list[$urandom_range(0, key_list.size() - 1)];
      frame(code, ($urandom_range(0, 15) == 0), 0, 0, $sformatf("rnd%0d", n));
      if (m_brk && $urandom_range(0, 1) == 1) begin
        // Follow a break prefix with the held key often enough to exercise releases.
        foreach (ascii_of[k]) if (ascii_of[k] == m_byte) code = k;
        frame(code, 0, 0, 0, $sformatf("rnd_rel%0d", n));
      end
    end

    // Reset in mid-frame: partial frame dropped silently
    drive_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 0);
    ps2_data = 1'b1;
    fe0 = fe_cnt;
    @(posedge clk); rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(TMO + 50);
    m_ext = 0; m_brk = 0; m_state = 0; m_byte = 8'h00;
    check("midrst.err", fe_cnt - fe0, 0);
    check("midrst.byte", ps2_byte, 0);
    check("midrst.state", ps2_state, 0);
    frame(8'h45, 0, 0, 0, "post_rst_0");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
